// File: rtl/arbitro_actuadores.sv
// Arbiter for the shared 12 V relay driver: pump (bomba), lamp (bombillo) and fan
// (ventilador). One load at a time, fixed priority bomba > bombillo > ventilador,
// a dead time with every relay off between loads, a minimum on-time before
// preemption, and a pump run limit followed by a pump lockout counted in minutes.
//
// Requests are plain levels with no handshake. A load holds its grant while its
// request stays high. Dropping the request releases the relay on the next cycle.
module arbitro_actuadores #(
  parameter int unsigned DEAD_CYC   = 8,
  parameter int unsigned MIN_ON     = 5,
  parameter int unsigned MAX_BOMBA  = 10,
  parameter int unsigned BLOQ_BOMBA = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tickMin,
  input  logic       reqBomba,
  input  logic       reqBombillo,
  input  logic       reqVent,
  output logic       prenderBomba,
  output logic       prenderBombillo,
  output logic       prenderVent,
  output logic [1:0] concedido,
  output logic       ocupado,
  output logic       bombaBloq
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    PAUSA  = 2'd1,
    ACTIVO = 2'd2
  } estado_t;

  estado_t    estado, estado_n;
  logic [1:0] conc_q, conc_n;
  logic [7:0] dead_cnt, dead_n;
  logic [7:0] min_cnt, min_n;
  logic [7:0] bloq_cnt, bloq_n;

  logic       eleg_bomba;
  logic [1:0] ganador;
  logic       req_conc;
  logic       mayor;
  logic       forzada;
  logic       salir;

  // The pump only competes while its lockout has run out.
  assign eleg_bomba = reqBomba && (bloq_cnt == 8'd0);

  // Fixed-priority winner among the eligible requests (lower code wins).
  always_comb begin
    ganador = 2'd0;
    if (eleg_bomba)       ganador = 2'd1;
    else if (reqBombillo) ganador = 2'd2;
    else if (reqVent)     ganador = 2'd3;
  end

  // Request level of the load currently holding the grant.
  always_comb begin
    req_conc = 1'b0;
    case (conc_q)
      2'd1:    req_conc = reqBomba;
      2'd2:    req_conc = reqBombillo;
      2'd3:    req_conc = reqVent;
      default: req_conc = 1'b0;
    endcase
  end

  // Exit conditions while a load is energised.
  assign mayor   = (ganador != 2'd0) && (ganador < conc_q);
  assign forzada = (conc_q == 2'd1) && (min_cnt >= 8'(MAX_BOMBA));
  assign salir   = (estado == ACTIVO) &&
                   (!req_conc || ((min_cnt >= 8'(MIN_ON)) && mayor) || forzada);

  // Next state, grant, dead-time and on-time counters.
  always_comb begin
    estado_n = estado;
    conc_n   = conc_q;
    dead_n   = dead_cnt;
    min_n    = min_cnt;
    case (estado)
      REPOSO: begin
        conc_n = 2'd0;
        if (ganador != 2'd0) begin
          conc_n   = ganador;
          dead_n   = 8'(DEAD_CYC);
          estado_n = PAUSA;
        end
      end
      PAUSA: begin
        if (dead_cnt <= 8'd1) begin
          // Last dead cycle: re-arbitrate with the requests present now.
          dead_n = 8'd0;
          conc_n = ganador;
          if (ganador != 2'd0) begin
            estado_n = ACTIVO;
            min_n    = 8'd0;
          end else begin
            estado_n = REPOSO;
          end
        end else begin
          dead_n = dead_cnt - 8'd1;
        end
      end
      ACTIVO: begin
        if (salir) begin
          estado_n = PAUSA;
          dead_n   = 8'(DEAD_CYC);
        end else if (tickMin && (min_cnt != 8'hFF)) begin
          min_n = min_cnt + 8'd1;
        end
      end
      default: begin
        estado_n = REPOSO;
        conc_n   = 2'd0;
      end
    endcase
  end

  // Pump lockout: a forced stop reloads it (over any tick), otherwise it counts minutes down.
  always_comb begin
    bloq_n = bloq_cnt;
    if (salir && forzada) begin
      bloq_n = 8'(BLOQ_BOMBA);
    end else if (tickMin && (bloq_cnt != 8'd0)) begin
      bloq_n = bloq_cnt - 8'd1;
    end
  end

  // State and counter registers; reset drops every relay at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= REPOSO;
      conc_q   <= 2'd0;
      dead_cnt <= 8'd0;
      min_cnt  <= 8'd0;
      bloq_cnt <= 8'd0;
    end else begin
      estado   <= estado_n;
      conc_q   <= conc_n;
      dead_cnt <= dead_n;
      min_cnt  <= min_n;
      bloq_cnt <= bloq_n;
    end
  end

  // Relay enables decode straight from the registered state, so only one can be high.
  assign prenderBomba    = (estado == ACTIVO) && (conc_q == 2'd1);
  assign prenderBombillo = (estado == ACTIVO) && (conc_q == 2'd2);
  assign prenderVent     = (estado == ACTIVO) && (conc_q == 2'd3);
  assign concedido       = conc_q;
  assign ocupado         = (estado != REPOSO);
  assign bombaBloq       = (bloq_cnt != 8'd0);

endmodule

// File: tb/tb_arbitro_actuadores.sv
// Bench for arbitro_actuadores: directed scenarios followed by random request
// toggling, every cycle compared against a minute/cycle-level model of the relay
// sharing rules.
module tb_arbitro_actuadores;

  localparam int DEAD   = 8;
  localparam int MIN_ON = 5;
  localparam int MAX_B  = 10;
  localparam int BLOQ   = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tickMin = 1'b0;
  logic       reqBomba = 1'b0;
  logic       reqBombillo = 1'b0;
  logic       reqVent = 1'b0;
  logic       prenderBomba;
  logic       prenderBombillo;
  logic       prenderVent;
  logic [1:0] concedido;
  logic       ocupado;
  logic       bombaBloq;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: which load is on (0 none), last grant shown, dead cycles left,
  // minutes the current load has been on, lockout minutes left.
  int m_load, m_pend, m_gap, m_min, m_lock;
  int zero_run;

  arbitro_actuadores #(
    .DEAD_CYC(DEAD), .MIN_ON(MIN_ON), .MAX_BOMBA(MAX_B), .BLOQ_BOMBA(BLOQ)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tickMin(tickMin),
    .reqBomba(reqBomba), .reqBombillo(reqBombillo), .reqVent(reqVent),
    .prenderBomba(prenderBomba), .prenderBombillo(prenderBombillo),
    .prenderVent(prenderVent), .concedido(concedido),
    .ocupado(ocupado), .bombaBloq(bombaBloq)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int best(input bit eb, input bit rl, input bit rv);
    if (eb) return 1;
    if (rl) return 2;
    if (rv) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_load = 0; m_pend = 0; m_gap = 0; m_min = 0; m_lock = 0; zero_run = 0;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_step(input bit t, input bit rb, input bit rl, input bit rv);
    int  win;
    bit  own;
    bit  forced;
    bit  lock_load;
    win = best(rb && (m_lock == 0), rl, rv);
    lock_load = 1'b0;
    if (m_load != 0) begin
      own    = (m_load == 1) ? rb : (m_load == 2) ? rl : rv;
      forced = (m_load == 1) && (m_min >= MAX_B);
      if (!own || (m_min >= MIN_ON && win != 0 && win < m_load) || forced) begin
        m_load = 0;
        m_gap  = DEAD;
        lock_load = forced;
      end else if (t) begin
        m_min = (m_min < 255) ? m_min + 1 : 255;
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_pend = win;
        m_load = win;
        m_min  = 0;
      end
    end else begin
      m_pend = win;
      if (win != 0) m_gap = DEAD;
    end
    if (lock_load)              m_lock = BLOQ;
    else if (t && m_lock > 0)   m_lock--;
  endtask

  task automatic compare_all();
    int ones;
    ones = int'(prenderBomba) + int'(prenderBombillo) + int'(prenderVent);
    chk("prenderBomba",    int'(prenderBomba),    int'(m_load == 1));
    chk("prenderBombillo", int'(prenderBombillo), int'(m_load == 2));
    chk("prenderVent",     int'(prenderVent),     int'(m_load == 3));
    chk("concedido",       int'(concedido),       m_pend);
    chk("ocupado",         int'(ocupado),         int'(m_load != 0 || m_gap > 0));
    chk("bombaBloq",       int'(bombaBloq),       int'(m_lock != 0));
    chk("one_relay",       int'(ones <= 1),       1);
    if (ones == 0) begin
      zero_run++;
    end else begin
      if (zero_run > 0) chk("dead_gap", int'(zero_run >= DEAD), 1);
      zero_run = 0;
    end
  endtask

  // One cycle: check the state left by the previous edge, then drive the next inputs.
  task automatic step(input bit t, input bit rb, input bit rl, input bit rv);
    @(negedge clk);
    compare_all();
    tickMin = t; reqBomba = rb; reqBombillo = rl; reqVent = rv;
    model_step(t, rb, rl, rv);
  endtask

  task automatic steps(input int n, input bit rb, input bit rl, input bit rv);
    for (int i = 0; i < n; i++) step(1'b0, rb, rl, rv);
  endtask

  // Look at the outputs just after the coming edge without disturbing the step rhythm.
  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tickMin = 0; reqBomba = 0; reqBombillo = 0; reqVent = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bit rb, rl, rv, t;

    // Reset state
    do_reset();
    #1;
    chk("rst_prenderBomba", int'(prenderBomba), 0);
    chk("rst_concedido",    int'(concedido),    0);
    chk("rst_ocupado",      int'(ocupado),      0);
    chk("rst_bombaBloq",    int'(bombaBloq),    0);

    // Lamp alone, then reset while it is on
    steps(9, 0, 1, 0);
    peek();
    chk("lamp_on",        int'(prenderBombillo), 1);
    chk("lamp_concedido", int'(concedido),       2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_lamp",    int'(prenderBombillo), 0);
    chk("async_rst_ocupado", int'(ocupado),         0);
    chk("async_rst_conc",    int'(concedido),       0);
    @(negedge clk);
    rst_n = 1'b1;
    tickMin = 0; reqBomba = 0; reqBombillo = 0; reqVent = 0;
    model_reset();

    // Lamp and fan together: lamp first, fan after the lamp drops
    steps(9, 0, 1, 1);
    peek();
    chk("lamp_over_fan", int'(prenderBombillo), 1);
    steps(9, 0, 0, 1);
    peek();
    chk("fan_on",        int'(prenderVent), 1);
    chk("fan_concedido", int'(concedido),   3);
    steps(12, 0, 0, 0);

    // Lamp on, pump arrives after 2 minutes: no preemption until MIN_ON
    steps(9, 0, 1, 0);
    step(1, 0, 1, 0); step(0, 0, 1, 0);
    step(1, 0, 1, 0); step(0, 0, 1, 0);
    steps(4, 1, 1, 0);
    peek();
    chk("no_early_preempt", int'(prenderBombillo), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0); step(0, 1, 1, 0);
    end
    peek();
    chk("preempted_lamp", int'(prenderBombillo), 0);
    steps(9, 1, 1, 0);
    peek();
    chk("pump_on",        int'(prenderBomba), 1);
    chk("pump_concedido", int'(concedido),    1);

    // Pump held for MAX_BOMBA minutes: forced off and locked out
    steps(2, 1, 0, 0);
    for (int i = 0; i < MAX_B; i++) begin
      step(1, 1, 0, 0); step(0, 1, 0, 0);
    end
    peek();
    chk("pump_forced_off", int'(prenderBomba), 0);
    chk("pump_locked",     int'(bombaBloq),    1);
    for (int i = 0; i < BLOQ - 1; i++) begin
      step(1, 1, 0, 0); step(0, 1, 0, 0);
    end
    peek();
    chk("pump_still_locked", int'(bombaBloq),    1);
    chk("pump_ignored",      int'(prenderBomba), 0);
    step(1, 1, 0, 0); step(0, 1, 0, 0);
    steps(9, 1, 0, 0);
    peek();
    chk("pump_regranted", int'(prenderBomba), 1);

    // Request dropped in the same cycle as a minute tick
    step(1, 0, 0, 0);
    peek();
    chk("drop_with_tick_off",  int'(prenderBomba), 0);
    chk("drop_with_tick_busy", int'(ocupado),      1);
    steps(12, 0, 0, 0);

    // Random toggling of all three requests
    rb = 0; rl = 0; rv = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 24) == 0) rb = ~rb;
      if ($urandom_range(0, 24) == 0) rl = ~rl;
      if ($urandom_range(0, 24) == 0) rv = ~rv;
      t = ($urandom_range(0, 9) == 0);
      step(t, rb, rl, rv);
    end
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
